// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_WIDTH   = 8;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and wraps.
// bit_end marks the last cycle of a bit period. bit_pre_end marks the cycle
// before it, so registered outputs can line up with the final cycle.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic asyn_rst,
  input  logic clear,
  input  logic run,
  output logic bit_end,
  output logic bit_pre_end
);

  logic [CW-1:0] count;

  assign bit_end     = run && (count == CW'(CLKS_PER_BIT - 1));
  assign bit_pre_end = run && (count == CW'(CLKS_PER_BIT - 2));

  // Count within the current bit period; clear forces a fresh period.
  always_ff @(posedge clk or negedge asyn_rst) begin
    if (!asyn_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= bit_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a FIFO one word at a time and sends each word as a UART frame:
// one start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
//
// FIFO handshake: RD_EN is a single-cycle pop request, raised only in IDLE
// when tx_en is high and f_empty is low. The popped word is taken from f_out
// during the following cycle (FETCH). No further pop is issued until the frame
// has fully left the line and the FSM is back in IDLE.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  localparam int IW = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  asyn_rst,
  input  logic                  tx_en,
  input  logic [DATA_WIDTH-1:0] f_out,
  input  logic                  f_empty,
  output logic                  RD_EN,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            state_dbg
);

  uart_state_e           state, state_n;
  logic [IW-1:0]         bit_idx, bit_idx_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  pop, clear, run;
  logic                  bit_end, bit_pre_end;
  logic                  tx_n, busy_n, frame_done_n;

  assign run       = (state == START) || (state == DATA) || (state == STOP);
  assign state_dbg = state;
  // Held low while reset is asserted even though the FSM already sits in IDLE.
  assign RD_EN     = asyn_rst && pop;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk         (clk),
    .asyn_rst    (asyn_rst),
    .clear       (clear),
    .run         (run),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

  // Next-state, pop request and datapath updates; phases advance on bit_end.
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en && !f_empty) begin
          pop     = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        shift_n = f_out;
        clear   = 1'b1;
        state_n = START;
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_idx == IW'(DATA_WIDTH - 1)) begin
            state_n   = STOP;
            bit_idx_n = '0;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx == IW'(STOP_BITS - 1)) begin
            state_n   = IDLE;
            bit_idx_n = '0;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with
  // the state register (tx falls two cycles after the pop, no glitches).
  always_comb begin
    tx_n         = 1'b1;
    busy_n       = (state_n != IDLE);
    frame_done_n = (state == STOP) && bit_pre_end &&
                   (bit_idx == IW'(STOP_BITS - 1));
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset returns the line to idle.
  always_ff @(posedge clk or negedge asyn_rst) begin
    if (!asyn_rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, per-cycle frame reference, directed and
// random scenarios, plus a second instance with two stop bits.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic asyn_rst;
  always #5 clk = ~clk;

  // ---------------- DUT (1 stop bit) ----------------
  logic          tx_en;
  logic [DW-1:0] f_out;
  logic          f_empty;
  logic          RD_EN, tx, busy, frame_done;
  logic [2:0]    state_dbg;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk        (clk),
    .asyn_rst   (asyn_rst),
    .tx_en      (tx_en),
    .f_out      (f_out),
    .f_empty    (f_empty),
    .RD_EN      (RD_EN),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- DUT (2 stop bits) ----------------
  logic          tx_en2, f_empty2;
  logic [DW-1:0] f_out2;
  logic          RD_EN2, tx2, busy2, frame_done2;
  logic [2:0]    state_dbg2;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk        (clk),
    .asyn_rst   (asyn_rst),
    .tx_en      (tx_en2),
    .f_out      (f_out2),
    .f_empty    (f_empty2),
    .RD_EN      (RD_EN2),
    .tx         (tx2),
    .busy       (busy2),
    .frame_done (frame_done2),
    .state_dbg  (state_dbg2)
  );

  // ---------------- counters / scoreboard ----------------
  int tests_run = 0;
  int failed    = 0;
  int cyc       = 0;

  logic [DW-1:0] fifo_q[$];   // contents of the FIFO feeding the DUT
  logic [DW-1:0] mdl_q[$];    // reference copy of what should still be popped
  int            fifo_cnt = 0;
  logic [2:0]    exp_q[$];    // expected {tx, busy, frame_done} per cycle
  int            rd_cycles[$];
  int            fd_cycles[$];

  assign f_empty = (fifo_cnt == 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Expected {tx, busy, frame_done} k cycles after the pop cycle (k >= 1).
  function automatic logic [2:0] frame_bit(input logic [DW-1:0] b, input int sb, input int k);
    int   len, seg;
    logic t;
    len = 1 + (1 + DW + sb) * CPB;
    if (k == 1) return 3'b110;          // word being fetched, line still idle
    seg = (k - 2) / CPB;
    if (seg == 0)       t = 1'b0;       // start bit
    else if (seg <= DW) t = b[seg-1];   // data, LSB first
    else                t = 1'b1;       // stop bit(s)
    return {t, 1'b1, (k == len)};
  endfunction

  // ---------------- FIFO model ----------------
  task automatic push_byte(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    mdl_q.push_back(b);
    fifo_cnt++;
  endtask

  always @(posedge clk) begin
    if (RD_EN && fifo_q.size() > 0) begin
      f_out    <= fifo_q.pop_front();
      fifo_cnt <= fifo_cnt - 1;
    end
  end

  // ---------------- per-cycle reference check ----------------
  always @(negedge clk) begin
    logic [2:0]    cur;
    logic          cur_idle, exp_rd;
    logic [DW-1:0] b;
    #2;
    cyc++;
    cur_idle = 1'b1;
    cur      = 3'b100;
    if (!asyn_rst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      cur      = exp_q.pop_front();
      cur_idle = 1'b0;
    end
    check("tx", tx, cur[2]);
    check("busy", busy, cur[1]);
    check("frame_done", frame_done, cur[0]);
    exp_rd = cur_idle && asyn_rst && tx_en && (mdl_q.size() > 0);
    check("rd_en", RD_EN, exp_rd);
    if (exp_rd) begin
      b = mdl_q.pop_front();
      for (int k = 1; k <= 1 + (2 + DW) * CPB; k++) exp_q.push_back(frame_bit(b, 1, k));
    end
    if (RD_EN) rd_cycles.push_back(cyc);
    if (frame_done) fd_cycles.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pop(output int c);
    int n0;
    n0 = rd_cycles.size();
    c  = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #3;
      if (rd_cycles.size() > n0) begin
        c = rd_cycles[$];
        return;
      end
    end
    check("pop_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #3;
      if (exp_q.size() == 0 && !busy && (mdl_q.size() == 0 || !tx_en)) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rd0, fd0, c;
    asyn_rst = 1'b0;
    tx_en    = 1'b1;
    tx_en2   = 1'b0;
    f_empty2 = 1'b1;
    f_out2   = 8'h81;
    f_out    = '0;

    // Reset held with a non-empty FIFO and tx_en high: no pop, line idle.
    push_byte(8'hA5);
    repeat (6) @(negedge clk);
    #3 check("rst_rd_en", RD_EN, 0);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    @(negedge clk);
    asyn_rst = 1'b1;
    #1 check("first_pop", RD_EN, 1);

    // 8'hA5 frame; frame_done in the last stop cycle.
    wait_idle();
    check("a5_pops", rd_cycles.size(), 1);
    check("a5_fd_count", fd_cycles.size(), 1);
    check("a5_fd_offset", fd_cycles[$] - rd_cycles[$], 41);

    // 8'h00 then 8'hFF back to back.
    @(negedge clk);
    rd0 = rd_cycles.size();
    fd0 = fd_cycles.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_idle();
    check("b2b_pops", rd_cycles.size() - rd0, 2);
    check("b2b_gap", rd_cycles[$] - rd_cycles[$-1], 42);
    check("b2b_fd_count", fd_cycles.size() - fd0, 2);
    check("b2b_empty", f_empty, 1);
    check("b2b_busy", busy, 0);

    // tx_en low holds off pops; dropping it mid-frame finishes that frame only.
    @(negedge clk);
    tx_en = 1'b0;
    push_byte(8'($urandom));
    rd0 = rd_cycles.size();
    repeat (20) @(negedge clk);
    check("hold_no_pop", rd_cycles.size() - rd0, 0);
    tx_en = 1'b1;
    wait_pop(c);
    repeat (12) @(negedge clk);
    tx_en = 1'b0;
    push_byte(8'($urandom));
    wait_idle();
    repeat (10) @(negedge clk);
    check("drop_en_pops", rd_cycles.size() - rd0, 1);
    tx_en = 1'b1;
    wait_idle();

    // Reset in the third data bit of 8'h3C: line idles at once, no frame_done.
    @(negedge clk);
    push_byte(8'h3C);
    wait_pop(c);
    fd0 = fd_cycles.size();
    repeat (14) @(negedge clk);
    asyn_rst = 1'b0;
    #3 check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    asyn_rst = 1'b1;
    rd0 = rd_cycles.size();
    repeat (20) @(negedge clk);
    check("midrst_no_pop", rd_cycles.size() - rd0, 0);
    check("midrst_no_fd", fd_cycles.size() - fd0, 0);

    // Random bursts with random tx_en gating.
    for (int it = 0; it < 10; it++) begin
      @(negedge clk);
      for (int n = $urandom_range(0, 3); n > 0; n--) push_byte(8'($urandom));
      tx_en = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(5, 70)) @(negedge clk);
    end
    tx_en = 1'b1;
    wait_idle();

    // Two stop bits, 8'h81: eight-cycle stop phase, frame_done in its last cycle.
    @(negedge clk);
    tx_en2   = 1'b1;
    f_empty2 = 1'b0;
    #2 check("sb2_pop", RD_EN2, 1);
    for (int k = 1; k <= 1 + (3 + DW) * CPB; k++) begin
      logic [2:0] e;
      @(negedge clk);
      if (k == 1) f_empty2 = 1'b1;
      #2;
      e = frame_bit(8'h81, 2, k);
      check("sb2_tx", tx2, e[2]);
      check("sb2_busy", busy2, e[1]);
      check("sb2_frame_done", frame_done2, e[0]);
      check("sb2_rd_en", RD_EN2, 0);
    end
    @(negedge clk); #2;
    check("sb2_idle_busy", busy2, 0);
    check("sb2_idle_tx", tx2, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
